fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 86 ++++++++
 tb/tb_fetch_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end: PC, imem drive, decode FIFO
module fetch_stage #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_instru,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [31:0]              id_instru,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_pc_plus4,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   r_pc;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instru[DEPTH];

  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_count_next;

  assign w_pop  = id_valid & id_ready;
  // A full buffer may still accept a fetch when the head leaves in the same cycle.
  assign w_push = ~reset & ~redirect & ((r_count < FULL) | w_pop);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_pc    <= {redirect_pc[31:2], 2'b00};
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc   <= r_pc + 32'd4;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_next;
    end
  end

  // Storage carries no reset; occupancy is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wptr]     <= r_pc;
      r_mem_instru[r_wptr] <= imem_instru;
    end
  end

  assign imem_addr   = r_pc;
  assign fifo_count  = r_count;
  assign id_valid    = (r_count != '0);
  assign id_instru   = id_valid ? r_mem_instru[r_rptr] : 32'd0;
  assign id_pc       = id_valid ? r_mem_pc[r_rptr] : 32'd0;
  assign id_pc_plus4 = id_valid ? (r_mem_pc[r_rptr] + 32'd4) : 32'd0;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, redirect, id_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_instru;
  logic        id_valid;
  logic [31:0] id_instru, id_pc, id_pc_plus4;
  logic [2:0]  fifo_count;

  logic        reset1;
  logic [31:0] imem_addr1, imem_instru1;
  logic        id_valid1;
  logic [31:0] id_instru1, id_pc1, id_pc_plus41;
  logic [2:0]  fifo_count1;

  assign imem_instru  = imem_addr ^ KEY;
  assign imem_instru1 = imem_addr1 ^ KEY;

  fetch_stage #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instru(imem_instru),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_instru(id_instru), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .fifo_count(fifo_count)
  );

  fetch_stage #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset1), .imem_addr(imem_addr1), .imem_instru(imem_instru1),
    .redirect(1'b0), .redirect_pc(32'd0), .id_ready(1'b1),
    .id_valid(id_valid1), .id_instru(id_instru1), .id_pc(id_pc1),
    .id_pc_plus4(id_pc_plus41), .fifo_count(fifo_count1)
  );

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    int          ecnt;
    logic [31:0] eaddr;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic v, input logic [31:0] pc,
                          input int cnt, input logic [31:0] addr,
                          input logic av, input logic [31:0] apc, input logic [31:0] ains,
                          input logic [31:0] ap4, input logic [2:0] acnt,
                          input logic [31:0] aaddr);
    chk({tag, " id_valid"},    {31'd0, av}, {31'd0, v});
    chk({tag, " id_pc"},       apc,  v ? pc : 32'd0);
    chk({tag, " id_instru"},   ains, v ? (pc ^ KEY) : 32'd0);
    chk({tag, " id_pc_plus4"}, ap4,  v ? (pc + 32'd4) : 32'd0);
    chk({tag, " fifo_count"},  {29'd0, acnt}, 32'(cnt));
    chk({tag, " imem_addr"},   aaddr, addr);
  endtask

  initial begin
    //            rst redir rpc           rdy ev  epc           cnt eaddr
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1, 32'h4};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1, 32'h8};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   1, 32'hC};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   1, 32'h4};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   2, 32'h8};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   3, 32'hC};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   4, 32'h10};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   4, 32'h10};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   4, 32'h10};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   4, 32'h14};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   4, 32'h18};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'hC,   4, 32'h1C};
    vecs[14] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'hC,   4, 32'h1C};
    vecs[15] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   0, 32'h0};
    vecs[16] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   1, 32'h4};
    vecs[17] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   2, 32'h8};
    vecs[18] = '{1'b0, 1'b1, 32'h43,  1'b0, 1'b1, 32'h0,   3, 32'hC};
    vecs[19] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   0, 32'h40};
    vecs[20] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h40,  1, 32'h44};
    vecs[21] = '{1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h44,  1, 32'h48};
    vecs[22] = '{1'b0, 1'b1, 32'h203, 1'b1, 1'b0, 32'h0,   0, 32'h100};
    vecs[23] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   0, 32'h200};
    vecs[24] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 1, 32'h204};
    vecs[25] = '{1'b1, 1'b1, 32'h500, 1'b0, 1'b1, 32'h200, 2, 32'h208};
    vecs[26] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   0, 32'h0};
    vecs[27] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1, 32'h4};

    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; id_ready = 1'b1;
    reset1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      reset       = vecs[i].rst;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      id_ready    = vecs[i].rdy;
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ecnt, vecs[i].eaddr,
               id_valid, id_pc, id_instru, id_pc_plus4, fifo_count, imem_addr);
      @(negedge clk);
    end

    // PC wrap across 2^32 on the second instance
    reset1 = 1'b0;
    #1;
    chk_outs("wrap0", 1'b0, 32'h0, 0, 32'hFFFF_FFF8,
             id_valid1, id_pc1, id_instru1, id_pc_plus41, fifo_count1, imem_addr1);
    @(negedge clk); #1;
    chk_outs("wrap1", 1'b1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFFC,
             id_valid1, id_pc1, id_instru1, id_pc_plus41, fifo_count1, imem_addr1);
    @(negedge clk); #1;
    chk_outs("wrap2", 1'b1, 32'hFFFF_FFFC, 1, 32'h0,
             id_valid1, id_pc1, id_instru1, id_pc_plus41, fifo_count1, imem_addr1);
    chk("wrap2 plus4_zero", id_pc_plus41, 32'h0);
    @(negedge clk); #1;
    chk_outs("wrap3", 1'b1, 32'h0, 1, 32'h4,
             id_valid1, id_pc1, id_instru1, id_pc_plus41, fifo_count1, imem_addr1);
    @(negedge clk); #1;
    chk_outs("wrap4", 1'b1, 32'h4, 1, 32'h8,
             id_valid1, id_pc1, id_instru1, id_pc_plus41, fifo_count1, imem_addr1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
